data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: accepts one CPU load/store in IDLE, inserts
// WAIT_CYCLES wait states, then pulses ready. `define MEM_ERR_CHECK_EN enables address checking.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        busy,
  output logic        addrError
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            op_rd_q, op_rd_d;
  logic            op_wr_q, op_wr_d;
  logic            flag_q, flag_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            aerr_q, aerr_d;

  logic [31:0]     mem [DEPTH];
  logic            mem_we;

  logic            req, both, squash, aerr_in;

  assign req  = memRead | memWrite;
  assign both = memRead & memWrite;

`ifdef MEM_ERR_CHECK_EN
  logic bad_addr;
  assign bad_addr = (address[1:0] != 2'b00) || (address[31:2] >= 30'(DEPTH));
  assign squash   = both | bad_addr;
  assign aerr_in  = both | bad_addr;
`else
  // Index wraps modulo DEPTH; byte offset and upper bits are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:AW+2], address[1:0]};
  assign squash  = both;
  assign aerr_in = 1'b0;
`endif

  // Outputs are registered one edge after the internal state, so the ready
  // cycle coincides with internal IDLE and the next request can be taken then.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    op_rd_d = op_rd_q;
    op_wr_d = op_wr_q;
    flag_d  = flag_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    aerr_d  = 1'b0;
    busy_d  = (state_q != IDLE);
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = address[AW+1:2];
          wdata_d = writeData;
          op_rd_d = memRead & ~squash;
          op_wr_d = memWrite & ~squash;
          flag_d  = aerr_in;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
        aerr_d  = flag_q;
        rdata_d = op_rd_q ? mem[idx_q] : 32'd0;
        mem_we  = op_wr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
      flag_q  <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_rd_q <= op_rd_d;
      op_wr_q <= op_wr_d;
      flag_q  <= flag_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      aerr_q  <= aerr_d;
    end
  end

  // Storage is deliberately not reset; the write is gated by reset-cleared state.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign readData  = rdata_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign addrError = aerr_q;

endmodule
